// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : uart_cmd_pkg
// Brief   : Shared state encoding and command codes for uart_cmd_ctrl.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_BUS  = 3'd5,
    ST_RSP  = 3'd6
  } state_t;

  localparam logic [7:0] CMD_WR       = 8'h01;
  localparam logic [7:0] CMD_RD       = 8'h02;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : uart_cmd_ctrl
// Brief   : UART byte-stream frame parser driving a simple register bus.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_rdy,
  output logic [7:0] o_bus_addr,
  output logic [7:0] o_bus_wdata,
  output logic       o_bus_wr,
  output logic       o_bus_rd,
  input  logic [7:0] i_bus_rdata,
  input  logic       i_bus_ack,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_valid,
  input  logic       i_rsp_rdy,
  output logic [7:0] o_err_count
);

  localparam int        TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  state_t        state_q, state_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          bus_wr_q, bus_wr_d;
  logic          bus_rd_q, bus_rd_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic byte_fire;
  logic in_frame;
  logic err_inc;

  assign byte_fire = i_rx_valid & ~rx_valid_q;
  assign in_frame  = (state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK});

  always_comb begin
    state_d     = state_q;
    rx_valid_d  = i_rx_valid;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    bus_wr_d    = bus_wr_q;
    bus_rd_d    = bus_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    tmo_d       = '0;
    err_inc     = 1'b0;

    if (in_frame) begin
      tmo_d = byte_fire ? '0 : tmo_q + TW'(1);
    end

    // Timeout wins over a byte landing in the same cycle; that byte is dropped.
    if (in_frame && (tmo_q == TMO_MAX)) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      err_inc = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (byte_fire && (i_rx_data == SYNC_BYTE)) state_d = ST_CMD;
        end
        ST_CMD: begin
          if (byte_fire) begin
            if ((i_rx_data == CMD_WR) || (i_rx_data == CMD_RD)) begin
              cmd_d   = i_rx_data;
              data_d  = 8'h00;
              state_d = ST_ADDR;
            end else begin
              state_d = ST_IDLE;
              err_inc = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (byte_fire) begin
            addr_d  = i_rx_data;
            state_d = (cmd_q == CMD_WR) ? ST_DATA : ST_CHK;
          end
        end
        ST_DATA: begin
          if (byte_fire) begin
            data_d  = i_rx_data;
            state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          if (byte_fire) begin
            if (i_rx_data == (cmd_q ^ addr_q ^ data_q)) begin
              bus_wr_d = (cmd_q == CMD_WR);
              bus_rd_d = (cmd_q == CMD_RD);
              state_d  = ST_BUS;
            end else begin
              state_d = ST_IDLE;
              err_inc = 1'b1;
            end
          end
        end
        ST_BUS: begin
          if (i_bus_ack) begin
            bus_wr_d = 1'b0;
            bus_rd_d = 1'b0;
            if (bus_rd_q) begin
              rsp_data_d  = i_bus_rdata;
              rsp_valid_d = 1'b1;
              state_d     = ST_RSP;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_RSP: begin
          if (i_rsp_rdy) begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    err_d    = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    rx_rdy_d = !(state_d inside {ST_BUS, ST_RSP});
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      rx_valid_q  <= 1'b0;
      rx_rdy_q    <= 1'b0;
      cmd_q       <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      bus_wr_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      err_q       <= 8'h00;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid_d;
      rx_rdy_q    <= rx_rdy_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      bus_wr_q    <= bus_wr_d;
      bus_rd_q    <= bus_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign o_rx_rdy    = rx_rdy_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = data_q;
  assign o_bus_wr    = bus_wr_q;
  assign o_bus_rd    = bus_rd_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_err_count = err_q;

endmodule
`default_nettype wire
